// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
//   Shared types for the sequenced 4-bit ALU block.
//   op_e    : command op codes presented on in_op.
//   state_e : handshake sequencer states (IDLE -> EXEC -> RESP).
package alu_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_OR  = 2'd1,
      OP_AND = 2'd2,
      OP_CAT = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_seq_ctrl_alu_core.sv
// alu_core
//   Purely combinational ALU: (a_i, b_i, op_i) -> 2W-bit zero-extended result.
//   Ports:
//     a_i      in  W    operand A
//     b_i      in  W    operand B
//     op_i     in  2    op code (op_e)
//     result_o out 2W   result
//   For OP_ADD the carry out of bit W-1 appears in result_o[W]; callers that
//   need a carry flag read it from there.
module alu_core
   import alu_seq_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0]   a_i,
   input  logic [W-1:0]   b_i,
   input  op_e            op_i,
   output logic [2*W-1:0] result_o
);

   logic [W:0] sum_s;

   assign sum_s = {1'b0, a_i} + {1'b0, b_i};

   // Result select; OR/AND are reductions producing a single flag bit.
   always_comb begin
      result_o = {(2*W){1'b0}};
      case (op_i)
         OP_ADD:  result_o = {{(W-1){1'b0}}, sum_s};
         OP_OR:   result_o = {{(2*W-1){1'b0}}, |(a_i | b_i)};
         OP_AND:  result_o = {{(2*W-1){1'b0}}, (&a_i) & (&b_i)};
         OP_CAT:  result_o = {a_i, b_i};
         default: result_o = {(2*W){1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl
//   Sequencer around alu_core. Accepts one command per in_valid/in_ready
//   handshake, runs it against the accumulator (B = acc[W-1:0]), stores the
//   result in the accumulator and presents it on out_valid/out_ready.
//   Ports:
//     Clock       in   1   rising-edge clock
//     Resetn      in   1   asynchronous active-low reset
//     in_valid    in   1   command present
//     in_ready    out  1   high only in IDLE while out of reset
//     in_op       in   2   op code (op_e)
//     in_a        in   W   operand A
//     in_clr      in   1   command clears the accumulator
//     out_valid   out  1   out_result holds a new result
//     out_ready   in   1   downstream accepts result
//     out_result  out  2W  registered result
//     acc         out  2W  accumulator (debug/display)
//     sticky_cy   out  1   sticky ADD carry, only with ALU_CARRY_FLAG_EN
//   Build option: define ALU_CARRY_FLAG_EN to add the sticky carry flag.
module alu_seq_ctrl
   import alu_seq_pkg::*;
#(
   parameter int W = 4
) (
   input  logic           Clock,
   input  logic           Resetn,
   input  logic           in_valid,
   output logic           in_ready,
   input  op_e            in_op,
   input  logic [W-1:0]   in_a,
   input  logic           in_clr,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] out_result,
   output logic [2*W-1:0] acc
`ifdef ALU_CARRY_FLAG_EN
   ,
   output logic           sticky_cy
`endif
);

   state_e         state_q, state_d;
   logic           idle_q, idle_d;
   logic           valid_q, valid_d;
   logic           accept_s, exec_s;
   op_e            cap_op_q;
   logic [W-1:0]   cap_a_q;
   logic           cap_clr_q;
   logic [2*W-1:0] acc_q, res_q;
   logic [2*W-1:0] alu_res_s, exec_res_s;

   // Ready is a registered IDLE flag, forced low while reset is asserted.
   assign in_ready   = idle_q & Resetn;
   assign out_valid  = valid_q;
   assign out_result = res_q;
   assign acc        = acc_q;

   // State register plus registered handshake flags.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         idle_q  <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idle_q  <= idle_d;
         valid_q <= valid_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_s) state_d = EXEC; else state_d = IDLE;
         EXEC:    state_d = RESP;
         RESP:    if (valid_q && out_ready) state_d = IDLE; else state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Output/strobe decode; flags are looked ahead from state_d so they register cleanly.
   always_comb begin
      accept_s = in_valid & in_ready;
      exec_s   = (state_q == EXEC);
      idle_d   = (state_d == IDLE);
      valid_d  = (state_d == RESP);
   end

   alu_core #(.W(W)) u_alu_core (
      .a_i      (cap_a_q),
      .b_i      (acc_q[W-1:0]),
      .op_i     (cap_op_q),
      .result_o (alu_res_s)
   );

   assign exec_res_s = cap_clr_q ? {(2*W){1'b0}} : alu_res_s;

   // Command capture at the accept edge; inputs are ignored afterwards.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         cap_op_q  <= OP_ADD;
         cap_a_q   <= {W{1'b0}};
         cap_clr_q <= 1'b0;
      end else if (accept_s) begin
         cap_op_q  <= in_op;
         cap_a_q   <= in_a;
         cap_clr_q <= in_clr;
      end else begin
         cap_op_q  <= cap_op_q;
         cap_a_q   <= cap_a_q;
         cap_clr_q <= cap_clr_q;
      end
   end

   // Accumulator and result update in the single EXEC cycle; held through RESP.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         acc_q <= {(2*W){1'b0}};
         res_q <= {(2*W){1'b0}};
      end else if (exec_s) begin
         acc_q <= exec_res_s;
         res_q <= exec_res_s;
      end else begin
         acc_q <= acc_q;
         res_q <= res_q;
      end
   end

`ifdef ALU_CARRY_FLAG_EN
   logic cy_q;

   assign sticky_cy = cy_q;

   // Sticky carry: set by a carrying ADD, cleared only by a clear command.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         cy_q <= 1'b0;
      end else if (exec_s && cap_clr_q) begin
         cy_q <= 1'b0;
      end else if (exec_s && (cap_op_q == OP_ADD) && alu_res_s[W]) begin
         cy_q <= 1'b1;
      end else begin
         cy_q <= cy_q;
      end
   end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl
//   Self-checking bench for alu_seq_ctrl: reset state, a table of directed
//   commands with fixed expected results, back-pressure hold, reset in the
//   middle of a command, then randomized commands against a rule-level model.
//   Sticky carry checks are compiled in when ALU_CARRY_FLAG_EN is defined.
module tb_alu_seq_ctrl;
   import alu_seq_pkg::*;

   localparam int W = 4;

   logic       Clock = 1'b0;
   logic       Resetn = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_clr = 1'b0;
   logic       out_ready = 1'b0;
   op_e        in_op = OP_ADD;
   logic [3:0] in_a = 4'd0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_result;
   logic [7:0] acc;
`ifdef ALU_CARRY_FLAG_EN
   logic       sticky_cy;
`endif

   int checks = 0;
   int failures = 0;
   int m_acc = 0;
   int m_cy = 0;

   typedef struct {
      op_e op;
      int  a;
      int  clr;
      int  exp_res;
      int  exp_cy;
   } vec_t;

   vec_t tbl[15];

   always #5 Clock = ~Clock;

   alu_seq_ctrl #(.W(W)) dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_a       (in_a),
      .in_clr     (in_clr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .acc        (acc)
`ifdef ALU_CARRY_FLAG_EN
      ,
      .sticky_cy  (sticky_cy)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of one command from the arithmetic rules, B being the accumulator low nibble.
   function automatic int model_res(op_e op, int a, int b, int clr);
      if (clr != 0) return 0;
      case (op)
         OP_ADD:  return a + b;
         OP_OR:   return (a != 0 || b != 0) ? 1 : 0;
         OP_AND:  return (a == 15 && b == 15) ? 1 : 0;
         OP_CAT:  return a * 16 + b;
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input op_e op, input int a, input int clr, output int r);
      int b;
      b = m_acc % 16;
      r = model_res(op, a, b, clr);
      if (clr != 0) m_cy = 0;
      else if (op == OP_ADD && a + b > 15) m_cy = 1;
      m_acc = r;
   endtask

   // Issue one command, check latency/handshake, hold in RESP for 'hold' cycles, complete.
   task automatic run_cmd(input op_e op, input int a, input int clr, input int hold,
                          output int got);
      int n;
      int exp_res;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge Clock); #1;
         n++;
      end
      chk("accept_ready", int'(in_ready), 1);
      in_valid = 1'b1;
      in_op    = op;
      in_a     = a[3:0];
      in_clr   = clr[0];
      @(posedge Clock); #1;
      model_step(op, a, clr, exp_res);
      // Scramble inputs: the captured command must not follow them.
      in_valid = 1'($urandom);
      in_a     = 4'($urandom);
      in_clr   = 1'($urandom);
      in_op    = op_e'(2'($urandom));
      chk("exec_out_valid", int'(out_valid), 0);
      chk("exec_in_ready", int'(in_ready), 0);
      @(posedge Clock); #1;
      chk("resp_out_valid", int'(out_valid), 1);
      chk("resp_result", int'(out_result), exp_res);
      chk("resp_acc", int'(acc), m_acc);
      chk("resp_in_ready", int'(in_ready), 0);
`ifdef ALU_CARRY_FLAG_EN
      chk("resp_sticky_cy", int'(sticky_cy), m_cy);
`endif
      got = int'(out_result);
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         in_valid  = 1'($urandom);
         in_a      = 4'($urandom);
         in_clr    = 1'($urandom);
         @(posedge Clock); #1;
         chk("hold_out_valid", int'(out_valid), 1);
         chk("hold_result", int'(out_result), exp_res);
         chk("hold_acc", int'(acc), m_acc);
         chk("hold_in_ready", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge Clock); #1;
      out_ready = 1'b0;
      chk("post_out_valid", int'(out_valid), 0);
      chk("post_in_ready", int'(in_ready), 1);
      chk("post_acc", int'(acc), m_acc);
   endtask

   initial begin
      int got;
      tbl[0]  = '{OP_ADD, 15, 1, 'h00, 0};  // clear ignores op
      tbl[1]  = '{OP_ADD, 15, 0, 'h0F, 0};  // F + 0
      tbl[2]  = '{OP_ADD,  1, 0, 'h10, 1};  // 1 + F carries
      tbl[3]  = '{OP_CAT, 10, 0, 'hA0, 1};  // sticky holds through CAT
      tbl[4]  = '{OP_OR,   3, 1, 'h00, 0};  // clear drops sticky
      tbl[5]  = '{OP_ADD,  5, 0, 'h05, 0};
      tbl[6]  = '{OP_CAT, 10, 0, 'hA5, 0};  // {A, 5}
      tbl[7]  = '{OP_CAT,  0, 1, 'h00, 0};
      tbl[8]  = '{OP_ADD, 15, 0, 'h0F, 0};
      tbl[9]  = '{OP_AND, 15, 0, 'h01, 0};  // F & F all ones
      tbl[10] = '{OP_AND, 15, 0, 'h00, 0};  // B = 1
      tbl[11] = '{OP_OR,   0, 0, 'h00, 0};  // 0 | 0
      tbl[12] = '{OP_OR,   3, 0, 'h01, 0};
      tbl[13] = '{OP_ADD, 15, 0, 'h10, 1};  // F + 1
      tbl[14] = '{OP_OR,   0, 0, 'h00, 1};  // B = low nibble of 10

      // Power-on reset.
      #2 Resetn = 1'b0;
      #10;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_acc", int'(acc), 0);
      chk("rst_out_result", int'(out_result), 0);
`ifdef ALU_CARRY_FLAG_EN
      chk("rst_sticky_cy", int'(sticky_cy), 0);
`endif
      @(negedge Clock);
      Resetn = 1'b1;
      #1;
      chk("rel_in_ready", int'(in_ready), 1);
      @(posedge Clock); #1;

      // Directed table.
      for (int i = 0; i < 15; i++) begin
         run_cmd(tbl[i].op, tbl[i].a, tbl[i].clr, 0, got);
         chk($sformatf("tbl%0d_result", i), got, tbl[i].exp_res);
`ifdef ALU_CARRY_FLAG_EN
         chk($sformatf("tbl%0d_sticky", i), int'(sticky_cy), tbl[i].exp_cy);
`endif
      end

      // Back-pressure: six cycles of out_ready low with in_valid toggling.
      run_cmd(OP_ADD, 9, 0, 6, got);
      chk("hold_cmd_result", got, 'h09);

      // Reset while a command is in RESP.
      in_valid = 1'b1; in_op = OP_ADD; in_a = 4'd7; in_clr = 1'b0;
      @(posedge Clock); #1;
      in_valid = 1'b0;
      @(posedge Clock); #1;
      chk("pre_reset_acc", int'(acc), 'h10);
      #2 Resetn = 1'b0;
      #1;
      chk("mid_rst_acc", int'(acc), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_out_result", int'(out_result), 0);
      chk("mid_rst_in_ready", int'(in_ready), 0);
`ifdef ALU_CARRY_FLAG_EN
      chk("mid_rst_sticky", int'(sticky_cy), 0);
`endif
      in_valid = 1'b1;
      @(posedge Clock); #1;
      chk("in_rst_acc", int'(acc), 0);
      in_valid = 1'b0;
      @(negedge Clock);
      Resetn = 1'b1;
      #1;
      chk("rel2_in_ready", int'(in_ready), 1);
      chk("rel2_out_valid", int'(out_valid), 0);
      m_acc = 0;
      m_cy  = 0;
      @(posedge Clock); #1;

      // Randomized commands against the model.
      for (int i = 0; i < 150; i++) begin
         run_cmd(op_e'(2'($urandom)), int'($urandom_range(15, 0)),
                 ($urandom_range(7, 0) == 0) ? 1 : 0, int'($urandom_range(2, 0)), got);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
